out_port_fifo_seq: RTL and testbench
====================================

OUT_PORT_FIFO_SEQ -- requirements
Module: out_port_fifo_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width matching the upstream 2x1 mux output.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entry count; power of two, minimum 2.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default 3, occupancy at which o_almost_full asserts; range 1..FIFO_DEPTH.
REQ-004 SHALL have port CLK, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1, upstream mux output valid; no backpressure to upstream.
REQ-007 SHALL have port i_data_bus, input, DATA_WIDTH, upstream mux output data.
REQ-008 SHALL have port i_ready, input, 1, downstream consumer ready.
REQ-009 SHALL have port o_valid, output, 1, head entry present.
REQ-010 SHALL have port o_data_bus, output, DATA_WIDTH, head entry, or all-zero dummy data when o_valid=0.
REQ-011 SHALL have port o_count, output, log2(FIFO_DEPTH)+1, current occupancy.
REQ-012 SHALL have port o_full, output, 1, occupancy equals FIFO_DEPTH.
REQ-013 SHALL have port o_empty, output, 1, occupancy equals 0.
REQ-014 SHALL have port o_almost_full, output, 1, occupancy >= ALMOST_FULL_LEVEL; drives the upstream mux enable controller.
REQ-015 SHALL have port o_overflow, output, 1, sticky flag: a push was dropped.
REQ-016 SHALL have port i_clear_ovf, input, 1, synchronous clear of o_overflow.

Function
REQ-017 Push SHALL occur on a rising edge when i_valid=1 and (occupancy<FIFO_DEPTH or pop occurs in the same cycle).
REQ-018 Pop SHALL occur on a rising edge when o_valid=1 and i_ready=1.
REQ-019 Push latency SHALL be 1 cycle: word sampled at edge N is presented on o_valid/o_data_bus after edge N when the FIFO was empty.
REQ-020 Ordering SHALL be strict FIFO, no reordering and no duplication.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; this holds at full (push accepted) and at one entry.
REQ-022 When the FIFO is empty, a simultaneous push SHALL NOT bypass: pop is impossible because o_valid=0.
REQ-023 When full with no pop, a push SHALL be dropped, storage SHALL be unchanged, and o_overflow SHALL set on that edge.
REQ-024 o_overflow SHALL hold until i_clear_ovf=1; when a clear and a new drop occur in the same cycle, set SHALL win.
REQ-025 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy SHALL be tracked by a separate counter.
REQ-026 o_count, o_full, o_empty and o_almost_full SHALL be derived from registered state only, with no combinational path from i_valid or i_ready.
REQ-027 o_data_bus SHALL be forced to zero whenever o_valid=0.

Reset
REQ-028 rst low SHALL immediately clear pointers, counter and o_overflow: o_valid=0, o_data_bus=0, o_count=0, o_empty=1, o_full=0, o_almost_full=0.
REQ-029 Storage array contents SHALL NOT be reset.
REQ-030 Reset asserted mid-stream SHALL discard all queued entries; the first push after rst deasserts SHALL be accepted normally.

Structure
REQ-031 A shared package/include SHALL hold the DATA_WIDTH default and the dummy-data zero constant, common with the crossbar mux stages.
REQ-032 A sub-module fifo_ptr_wrap (enable-driven wrapping pointer, asynchronous active-low reset) SHALL be instantiated twice, once per pointer.

Verification
REQ-033 Scenario: reset, then push 0xA1, 0xA2 with i_ready=0 -> o_count=2, o_data_bus=0xA1, o_valid=1.
REQ-034 Scenario: fill 4 entries 0x10..0x13, push 0x14 with i_ready=0 -> 0x14 dropped, o_overflow=1, o_full=1, and drain yields 0x10..0x13.
REQ-035 Scenario: full FIFO, push 0x20 with i_ready=1 -> 0x10 popped, 0x20 accepted, o_count stays 4, o_overflow unchanged.
REQ-036 Scenario: continuous push with i_ready=1 for 10 cycles (pointer wrap) -> output sequence equals input sequence, delayed 1 cycle, o_count<=1.
REQ-037 Scenario: 3 entries queued, rst pulsed low asynchronously mid-cycle -> outputs zero/empty immediately; the next push 0x55 appears one cycle later.
REQ-038 Scenario: o_overflow=1, i_clear_ovf=1 in the same cycle as a full-no-pop push -> o_overflow remains 1; clear in the next idle cycle -> 0.

Source files
------------

// File: rtl/out_port_fifo_seq_pkg.sv
// out_port_fifo_seq_pkg: constants shared by the output-port FIFO and the crossbar mux stages.
//   DEFAULT_DATA_WIDTH : payload width of the upstream 2x1 mux output
//   DUMMY_DATA         : all-zero word presented when no valid data is available
package out_port_fifo_seq_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DUMMY_DATA = '0;
endpackage

// File: rtl/out_port_fifo_seq_if.sv
// out_port_fifo_seq_if: upstream push, downstream pop and status signals of the output-port FIFO.
//   slave  : FIFO side (takes i_*, drives o_*)
//   master : environment side (drives i_*, takes o_*)
interface out_port_fifo_seq_if
    import out_port_fifo_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data_bus;
    logic                  i_ready;
    logic                  i_clear_ovf;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data_bus;
    logic [CW-1:0]         o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_overflow;
    modport slave (
        input  i_valid, i_data_bus, i_ready, i_clear_ovf,
        output o_valid, o_data_bus, o_count, o_full, o_empty, o_almost_full, o_overflow
    );
    modport master (
        output i_valid, i_data_bus, i_ready, i_clear_ovf,
        input  o_valid, o_data_bus, o_count, o_full, o_empty, o_almost_full, o_overflow
    );
endinterface

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: enable-driven pointer that wraps modulo 2**W.
//   CLK : clock, rst : asynchronous active-low reset
//   en  : advance by one, ptr : current pointer value
module fifo_ptr_wrap #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] ptr
);
    always_ff @(posedge CLK or negedge rst)
        if (!rst) ptr <= '0;
        else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/out_port_fifo_seq.sv
// out_port_fifo_seq: output-port FIFO behind the crossbar mux; drops pushes when full and flags overflow.
//   CLK : clock, rst : asynchronous active-low reset
//   bus : push side (i_valid/i_data_bus), pop side (i_ready/o_valid/o_data_bus),
//         status (o_count/o_full/o_empty/o_almost_full/o_overflow), i_clear_ovf
module out_port_fifo_seq
    import out_port_fifo_seq_pkg::*;
#(
    parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH        = 4,
    parameter int ALMOST_FULL_LEVEL = 3
) (
    input  logic              CLK,
    input  logic              rst,
    out_port_fifo_seq_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  ovf, full, pop, push, drop;

    assign full = count == CW'(FIFO_DEPTH);
    // pop depends only on registered occupancy, so a full FIFO can accept a push in a popping cycle
    assign pop  = (count != '0) && bus.i_ready;
    assign push = bus.i_valid && (!full || pop);
    assign drop = bus.i_valid && full && !pop;

    fifo_ptr_wrap #(.W(AW)) u_wr (.CLK(CLK), .rst(rst), .en(push), .ptr(wr_ptr));
    fifo_ptr_wrap #(.W(AW)) u_rd (.CLK(CLK), .rst(rst), .en(pop),  .ptr(rd_ptr));

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= bus.i_data_bus;

    always_ff @(posedge CLK or negedge rst)
        if (!rst) count <= '0;
        else count <= count + CW'(push) - CW'(pop);

    // a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge CLK or negedge rst)
        if (!rst) ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
        else if (bus.i_clear_ovf) ovf <= 1'b0;

    assign bus.o_valid       = count != '0;
    assign bus.o_data_bus    = bus.o_valid ? mem[rd_ptr] : DATA_WIDTH'(DUMMY_DATA);
    assign bus.o_count       = count;
    assign bus.o_full        = full;
    assign bus.o_empty       = count == '0;
    assign bus.o_almost_full = count >= CW'(ALMOST_FULL_LEVEL);
    assign bus.o_overflow    = ovf;
endmodule

// File: tb/tb_out_port_fifo_seq.sv
// tb_out_port_fifo_seq: directed stimulus with a scoreboard queue checked by a separate pop monitor.
module tb_out_port_fifo_seq;
    logic CLK = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] q[$];

    out_port_fifo_seq_if bus ();
    out_port_fifo_seq dut (.CLK(CLK), .rst(rst), .bus(bus));

    always #5 CLK = ~CLK;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    // pop monitor: a pop happens on the next rising edge whenever o_valid && i_ready
    always @(negedge CLK) begin
        if (rst && bus.o_valid && bus.i_ready) begin
            if (q.size() == 0) chk("unexpected_pop", bus.o_data_bus, 32'hDEAD_BEEF);
            else chk("pop_data", bus.o_data_bus, q.pop_front());
        end
        if (rst && !bus.o_valid) chk("dummy_zero", bus.o_data_bus, 32'h0);
    end

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c, input logic acc);
        bus.i_valid = v;
        bus.i_data_bus = d;
        bus.i_ready = r;
        bus.i_clear_ovf = c;
        if (v && acc) q.push_back(d);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_status(string n, int cnt, logic vld, logic fl, logic em, logic af, logic ov);
        chk({n, "_count"}, 32'(bus.o_count), 32'(cnt));
        chk({n, "_valid"}, 32'(bus.o_valid), 32'(vld));
        chk({n, "_full"}, 32'(bus.o_full), 32'(fl));
        chk({n, "_empty"}, 32'(bus.o_empty), 32'(em));
        chk({n, "_afull"}, 32'(bus.o_almost_full), 32'(af));
        chk({n, "_ovf"}, 32'(bus.o_overflow), 32'(ov));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_valid = 0; bus.i_data_bus = 0; bus.i_ready = 0; bus.i_clear_ovf = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk_status("reset", 0, 0, 0, 1, 0, 0);
        chk("reset_data", bus.o_data_bus, 32'h0);
        rst = 1'b1;
        // two pushes held with no consumer
        step(1, 32'hA1, 0, 0, 1);
        chk_status("lat1", 1, 1, 0, 0, 0, 0);
        chk("lat1_data", bus.o_data_bus, 32'hA1);
        step(1, 32'hA2, 0, 0, 1);
        chk_status("two", 2, 1, 0, 0, 0, 0);
        chk("two_data", bus.o_data_bus, 32'hA1);
        repeat (2) step(0, 0, 1, 0, 0);
        chk_status("drain1", 0, 0, 0, 1, 0, 0);
        // fill, then overflow
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h10 + i, 0, 0, 1);
            if (i == 2) chk_status("fill3", 3, 1, 0, 0, 1, 0);
        end
        chk_status("full", 4, 1, 1, 0, 1, 0);
        step(1, 32'h14, 0, 0, 0);
        chk_status("drop", 4, 1, 1, 0, 1, 1);
        chk("drop_head", bus.o_data_bus, 32'h10);
        // push and pop at full
        step(1, 32'h20, 1, 0, 1);
        chk_status("full_pp", 4, 1, 1, 0, 1, 1);
        chk("full_pp_head", bus.o_data_bus, 32'h11);
        // clear colliding with a drop: set wins
        step(1, 32'h21, 0, 1, 0);
        chk_status("clr_drop", 4, 1, 1, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk_status("clr_idle", 4, 1, 1, 0, 1, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        chk_status("drain2", 0, 0, 0, 1, 0, 0);
        // streaming through a pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h30 + i, 1, 0, 1);
            chk("stream_count", 32'(bus.o_count), 32'd1);
            chk("stream_head", bus.o_data_bus, 32'h30 + i);
        end
        step(0, 0, 1, 0, 0);
        chk_status("drain3", 0, 0, 0, 1, 0, 0);
        // one entry: push and pop together
        step(1, 32'h50, 0, 0, 1);
        step(1, 32'h51, 1, 0, 1);
        chk_status("one_pp", 1, 1, 0, 0, 0, 0);
        chk("one_pp_head", bus.o_data_bus, 32'h51);
        step(0, 0, 1, 0, 0);
        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 32'h40 + i, 0, 0, 1);
        chk_status("pre_rst", 3, 1, 0, 0, 1, 0);
        bus.i_valid = 0;
        #3;
        rst = 1'b0;
        q.delete();
        #1;
        chk_status("async_rst", 0, 0, 0, 1, 0, 0);
        chk("async_rst_data", bus.o_data_bus, 32'h0);
        #2;
        rst = 1'b1;
        @(posedge CLK);
        #1;
        step(1, 32'h55, 0, 0, 1);
        chk_status("post_rst", 1, 1, 0, 0, 0, 0);
        chk("post_rst_data", bus.o_data_bus, 32'h55);
        step(0, 0, 1, 0, 0);
        chk_status("final", 0, 0, 0, 1, 0, 0);
        chk("scoreboard_left", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
